// File: rtl/temp_display_pkg.sv
// Shared types and constants for the LM75 temperature display: FSM states,
// digit codes, active-low segment patterns and the double-dabble step.
package temp_display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_e;

  localparam logic [3:0] CODE_0     = 4'h0;
  localparam logic [3:0] CODE_1     = 4'h1;
  localparam logic [3:0] CODE_2     = 4'h2;
  localparam logic [3:0] CODE_3     = 4'h3;
  localparam logic [3:0] CODE_4     = 4'h4;
  localparam logic [3:0] CODE_5     = 4'h5;
  localparam logic [3:0] CODE_6     = 4'h6;
  localparam logic [3:0] CODE_7     = 4'h7;
  localparam logic [3:0] CODE_8     = 4'h8;
  localparam logic [3:0] CODE_9     = 4'h9;
  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_MINUS = 4'hB;

  // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  // One double-dabble step on {bcd[11:0], bin[7:0]}: add-3 correction, then shift.
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (r[8+4*i +: 4] >= 4'd5) r[8+4*i +: 4] = r[8+4*i +: 4] + 4'd3;
    end
    return {r[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Digit code to active-low 7-segment pattern; unknown codes show blank.
module seg7_decode
  import temp_display_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_n_o
);

  always_comb begin
    seg_n_o = SEG_BLANK;
    case (code_i)
      CODE_0:     seg_n_o = SEG_0;
      CODE_1:     seg_n_o = SEG_1;
      CODE_2:     seg_n_o = SEG_2;
      CODE_3:     seg_n_o = SEG_3;
      CODE_4:     seg_n_o = SEG_4;
      CODE_5:     seg_n_o = SEG_5;
      CODE_6:     seg_n_o = SEG_6;
      CODE_7:     seg_n_o = SEG_7;
      CODE_8:     seg_n_o = SEG_8;
      CODE_9:     seg_n_o = SEG_9;
      CODE_MINUS: seg_n_o = SEG_MINUS;
      default:    seg_n_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/temp_display.sv
// LM75 temperature word to multiplexed 4-digit 7-segment display (sXX.X).
// Define TEMP_DISPLAY_LZB_EN to blank leading zeros on the hundreds/tens digits.
module temp_display
  import temp_display_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data_in,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        busy,
  output logic        upd
);

  localparam int DWELL  = CLK_HZ / SCAN_HZ;
  localparam int SCAN_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_e      state_q, state_d;
  logic [8:0]  last_raw_q;
  logic [3:0]  cnt_q;
  logic        upd_q;
  logic [19:0] dd_q;
  logic        sign_cv_q, half_cv_q;
  logic        sign_q, half_q;
  logic [3:0]  hun_q, ten_q, unit_q;
  logic [SCAN_W-1:0] scan_q;
  logic [1:0]  dig_q;

  logic [8:0]  raw_in, mag_in;
  logic        changed, load, commit, blank_w;
  logic [3:0]  hun_code, ten_code, code_mux;
  logic        dp_mux;
  logic        unused_lsb;

  assign raw_in     = data_in[15:7];
  assign unused_lsb = ^data_in[6:0];
  assign mag_in     = raw_in[8] ? (~raw_in + 9'd1) : raw_in;
  assign changed    = (raw_in != last_raw_q);
  assign load       = (state_q == IDLE) && changed;
  assign commit     = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (changed) state_d = CONVERT;
      CONVERT: if (cnt_q == 4'd8) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and committed display value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_raw_q <= 9'h000;
      cnt_q      <= 4'd0;
      upd_q      <= 1'b0;
      sign_q     <= 1'b0;
      half_q     <= 1'b0;
      hun_q      <= 4'd0;
      ten_q      <= 4'd0;
      unit_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      upd_q   <= commit;
      if (load) begin
        last_raw_q <= raw_in;
        cnt_q      <= 4'd0;
      end else if (state_q == CONVERT) begin
        cnt_q <= cnt_q + 4'd1;
      end
      if (commit) begin
        sign_q <= sign_cv_q;
        half_q <= half_cv_q;
        hun_q  <= dd_q[19:16];
        ten_q  <= dd_q[15:12];
        unit_q <= dd_q[11:8];
      end
    end
  end

  // Converter datapath: loaded on entry to CONVERT, eight shifts, then held
  always_ff @(posedge clk) begin
    if (load) begin
      dd_q      <= {12'd0, mag_in[8:1]};
      sign_cv_q <= raw_in[8];
      half_cv_q <= mag_in[0];
    end else if ((state_q == CONVERT) && (cnt_q < 4'd8)) begin
      dd_q <= dd_step(dd_q);
    end
  end

  // Digit scan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
      dig_q  <= 2'd0;
    end else if (scan_q == SCAN_W'(DWELL - 1)) begin
      scan_q <= '0;
      dig_q  <= dig_q + 2'd1;
    end else begin
      scan_q <= scan_q + 1'b1;
    end
  end

`ifdef TEMP_DISPLAY_LZB_EN
  assign hun_code = (hun_q == 4'd0) ? CODE_BLANK : hun_q;
  assign ten_code = ((hun_q == 4'd0) && (ten_q == 4'd0)) ? CODE_BLANK : ten_q;
`else
  assign hun_code = hun_q;
  assign ten_code = ten_q;
`endif

  // First clock of every dwell is fully dark to avoid ghosting across digits.
  assign blank_w = (scan_q == '0);

  always_comb begin
    code_mux = CODE_BLANK;
    dp_mux   = 1'b1;
    case (dig_q)
      2'd3: code_mux = sign_q ? CODE_MINUS : hun_code;
      2'd2: code_mux = ten_code;
      2'd1: begin
        code_mux = unit_q;
        dp_mux   = 1'b0;
      end
      default: code_mux = half_q ? CODE_5 : CODE_0;
    endcase
    if (blank_w) begin
      code_mux = CODE_BLANK;
      dp_mux   = 1'b1;
    end
  end

  seg7_decode u_dec (
    .code_i  (code_mux),
    .seg_n_o (seg_n)
  );

  assign dp_n = dp_mux;
  assign an_n = blank_w ? 4'hF : ~(4'b0001 << dig_q);
  assign busy = (state_q != IDLE);
  assign upd  = upd_q;

endmodule

// File: tb/tb_temp_display.sv
// Randomized self-checking bench for temp_display against a decimal reference model.
module tb_temp_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data_in = 16'h0000;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        busy;
  logic        upd;

  int n_tests = 0;
  int n_fail  = 0;

  temp_display #(.CLK_HZ(1000), .SCAN_HZ(100)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .seg_n   (seg_n),
    .dp_n    (dp_n),
    .an_n    (an_n),
    .busy    (busy),
    .upd     (upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input int c);
    case (c)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  11: return 7'h3F;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected {dp_n, seg_n} per digit, from the temperature in decimal.
  function automatic logic [3:0][7:0] expect_digits(input logic [8:0] raw);
    logic [3:0][7:0] e;
    int t, a, ip, h, te, u, d3, d2;
    bit neg, lzb;
    t   = int'($signed(raw));
    neg = (t < 0);
    a   = neg ? -t : t;
    ip  = a / 2;
    h   = ip / 100;
    te  = (ip / 10) % 10;
    u   = ip % 10;
`ifdef TEMP_DISPLAY_LZB_EN
    lzb = 1'b1;
`else
    lzb = 1'b0;
`endif
    d3 = neg ? 11 : ((h == 0 && lzb) ? 10 : h);
    d2 = (lzb && h == 0 && te == 0) ? 10 : te;
    e[3] = {1'b1, seg_of(d3)};
    e[2] = {1'b1, seg_of(d2)};
    e[1] = {1'b0, seg_of(u)};
    e[0] = {1'b1, seg_of((a % 2 == 1) ? 5 : 0)};
    return e;
  endfunction

  task automatic check_disp(input string tag, input logic [8:0] raw);
    logic [3:0][8:0] obs;
    logic [3:0][7:0] e;
    int d;
    obs = '0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      d = -1;
      case (an_n)
        4'b1110: d = 0;
        4'b1101: d = 1;
        4'b1011: d = 2;
        4'b0111: d = 3;
        default: d = -1;
      endcase
      if (d >= 0) obs[d] = {1'b1, dp_n, seg_n};
    end
    e = expect_digits(raw);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_dig%0d", tag, k), 32'(obs[k]), 32'({1'b1, e[k]}));
  endtask

  task automatic wait_upd(input string tag);
    int got;
    got = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (upd) begin
        got = c;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(got), 32'd11);
    chk({tag, "_busy_low"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_pulse_width"}, 32'(upd), 32'd0);
  endtask

  task automatic do_conv(input logic [15:0] v, input string tag);
    @(negedge clk);
    data_in = v;
    wait_upd(tag);
    check_disp(tag, v[15:7]);
  endtask

  task automatic no_upd(input logic [15:0] v, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    data_in = v;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (upd || busy) n++;
    end
    chk(tag, 32'(n), 32'd0);
  endtask

  initial begin
    logic [3:0] ea;
    logic [15:0] v;
    logic [8:0] cur;
    int n_upd, t1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", 32'(seg_n), 32'h7F);
    chk("rst_dp", 32'(dp_n), 32'd1);
    chk("rst_an", 32'(an_n), 32'hF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_upd", 32'(upd), 32'd0);

    // Scan order and ghost blanking from release
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 45; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      ea = 4'hF;
      if (i % 10 != 0) ea[(i / 10) % 4] = 1'b0;
      chk($sformatf("scan_an_%0d", i), 32'(an_n), 32'(ea));
    end

    check_disp("reset_value", 9'h000);
    no_upd(16'h007F, "lsb_only_zero");

    do_conv(16'h1900, "p25_0");
    do_conv(16'h7D00, "p125_0");
    do_conv(16'hC900, "m55_0");
    do_conv(16'h7F80, "p127_5");
    do_conv(16'h8000, "m128_0");
    do_conv(16'hFF80, "m0_5");
    no_upd(16'hFFFF, "lsb_only_neg");

    // Back-to-back change while busy: both values converted, latest shown
    @(negedge clk);
    data_in = 16'h1900;
    n_upd = 0;
    t1 = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 3) data_in = 16'h7D00;
      if (upd) begin
        n_upd++;
        if (n_upd == 1) t1 = c;
      end
    end
    chk("b2b_count", 32'(n_upd), 32'd2);
    chk("b2b_first", 32'(t1), 32'd11);
    check_disp("b2b_final", 9'h0FA);
    no_upd(16'h7D7F, "lsb_only_pos");

    // Reset four clocks into CONVERT
    @(negedge clk);
    data_in = 16'h3200;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_seg", 32'(seg_n), 32'h7F);
    chk("abort_dp", 32'(dp_n), 32'd1);
    chk("abort_an", 32'(an_n), 32'hF);
    chk("abort_busy", 32'(busy), 32'd0);
    n_upd = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (upd) n_upd++;
    end
    chk("abort_no_upd", 32'(n_upd), 32'd0);
    data_in = 16'h1900;
    @(negedge clk);
    rst_n = 1'b1;
    wait_upd("after_abort");
    check_disp("after_abort", 9'h032);

    // Random temperatures
    cur = 9'h032;
    for (int r = 0; r < 10; r++) begin
      v = 16'($urandom);
      if (v[15:7] == cur) v[7] = ~v[7];
      cur = v[15:7];
      do_conv(v, $sformatf("rand%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
